// File: rtl/sha2_msg_dlvr_if.sv
// Host word stream into the SHA-2 message deliverer: 32-bit valid/ready with an end-of-message flag.
interface sha2_msg_dlvr_if;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic        in_last;

    modport master (output in_vld, output in_data, output in_last, input in_rdy);
    modport slave  (input in_vld, input in_data, input in_last, output in_rdy);
endinterface

// File: rtl/sha2_msg_dlvr.sv
// SHA-2 message deliverer: buffers a whole host message as 64-bit packets, then streams it
// gap-free into the IPU while holding the IPU out of reset until it reports msg_end.
module sha2_msg_dlvr #(
    parameter int unsigned MAX_PKTS = 16
) (
    input  logic            clk,
    input  logic            rst_b,
    sha2_msg_dlvr_if.slave  host,
    output logic [63:0]     pkt,
    output logic            lst_pkt,
    output logic            ipu_rst_b,
    output logic [63:0]     msg_len,
    input  logic            msg_end,
    output logic            busy,
    output logic            err
);

    localparam int unsigned PW = $clog2(MAX_PKTS) + 1;
    localparam int unsigned AW = PW - 1;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        STREAM   = 2'd1,
        WAIT_END = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] npkts_q, npkts_d;
    logic          half_q, half_d;
    logic [63:0]   pkt_q, pkt_d;
    logic          lst_q, lst_d;
    logic          ipu_rst_b_q, ipu_rst_b_d;
    logic [63:0]   len_q, len_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic [63:0]   mem_q [MAX_PKTS];
    logic          xfer_c;
    logic          wr_hi_c;
    logic          wr_lo_c;

    assign host.in_rdy = (state_q == COLLECT);
    assign xfer_c      = host.in_vld & host.in_rdy;
    assign wr_hi_c     = xfer_c & ~half_q;
    assign wr_lo_c     = xfer_c & half_q;

    // Packet buffer: first host word fills the upper half, second the lower half.
    always_ff @(posedge clk) begin
        if (wr_hi_c) begin
            mem_q[wp_q[AW-1:0]][63:32] <= host.in_data;
        end
        if (wr_lo_c) begin
            mem_q[wp_q[AW-1:0]][31:0] <= host.in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        npkts_d     = npkts_q;
        half_d      = half_q;
        pkt_d       = pkt_q;
        lst_d       = lst_q;
        ipu_rst_b_d = ipu_rst_b_q;
        len_d       = len_q;
        busy_d      = busy_q;
        err_d       = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (xfer_c) begin
                    if (!half_q) begin
                        if (host.in_last) begin
                            err_d  = 1'b1;
                            wp_d   = '0;
                            half_d = 1'b0;
                        end else begin
                            half_d = 1'b1;
                        end
                    end else begin
                        half_d = 1'b0;
                        if (host.in_last) begin
                            npkts_d     = wp_q + PW'(1);
                            len_d       = 64'({npkts_d, 6'b0});
                            // A one-packet message is still being written, so bypass the buffer.
                            pkt_d       = (wp_q == '0) ? {mem_q[0][63:32], host.in_data} : mem_q[0];
                            lst_d       = (wp_q == '0);
                            rp_d        = PW'(1);
                            ipu_rst_b_d = 1'b1;
                            busy_d      = 1'b1;
                            state_d     = STREAM;
                        end else if (wp_q == PW'(MAX_PKTS - 1)) begin
                            err_d = 1'b1;
                            wp_d  = '0;
                        end else begin
                            wp_d = wp_q + PW'(1);
                        end
                    end
                end
            end
            STREAM: begin
                if (lst_q) begin
                    pkt_d   = '0;
                    lst_d   = 1'b0;
                    state_d = WAIT_END;
                end else begin
                    pkt_d = mem_q[rp_q[AW-1:0]];
                    lst_d = (rp_q == npkts_q - PW'(1));
                    rp_d  = rp_q + PW'(1);
                end
            end
            WAIT_END: begin
                if (msg_end) begin
                    ipu_rst_b_d = 1'b0;
                    busy_d      = 1'b0;
                    len_d       = '0;
                    wp_d        = '0;
                    rp_d        = '0;
                    half_d      = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= COLLECT;
            wp_q        <= '0;
            rp_q        <= '0;
            npkts_q     <= '0;
            half_q      <= 1'b0;
            pkt_q       <= '0;
            lst_q       <= 1'b0;
            ipu_rst_b_q <= 1'b0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            npkts_q     <= npkts_d;
            half_q      <= half_d;
            pkt_q       <= pkt_d;
            lst_q       <= lst_d;
            ipu_rst_b_q <= ipu_rst_b_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign pkt       = pkt_q;
    assign lst_pkt   = lst_q;
    assign ipu_rst_b = ipu_rst_b_q;
    assign msg_len   = len_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
